// File: rtl/unaligned_fetch_ctrl.sv
// rtl/unaligned_fetch_ctrl.sv - unaligned beat fetch with byte-lane merge ahead of the alignment network
// Optional error reporting is enabled by defining UNALIGNED_FETCH_ERR_EN.
module unaligned_fetch_ctrl #(
    parameter int DATA_WIDTH = 64,
    parameter int WORD_WIDTH = 8,
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [LEN_WIDTH-1:0]  req_len,
    output logic                  mem_rd_valid,
    input  logic                  mem_rd_ready,
    output logic [ADDR_WIDTH-4:0] mem_rd_addr,
    input  logic                  mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] mem_rsp_data,
`ifdef UNALIGNED_FETCH_ERR_EN
    input  logic                  mem_rsp_err,
    output logic                  out_err,
`endif
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [2:0]            out_align_start,
    output logic                  out_reverse,
    output logic                  out_last
);
    localparam int LANES = DATA_WIDTH / WORD_WIDTH;

    typedef enum logic [1:0] {IDLE, RD_ISSUE, RD_WAIT, OUT} state_t;

    state_t                state;
    logic [ADDR_WIDTH-4:0] wptr;
    logic [2:0]            off;
    logic [LEN_WIDTH-1:0]  rem;
    logic                  prime;
    logic [DATA_WIDTH-1:0] hold;
    logic [DATA_WIDTH-1:0] merged;

    assign mem_rd_addr = wptr;
    assign out_reverse = 1'b0;

    // Lanes at or above off still belong to the older word; the network rotates them to the front.
    always_comb begin
        merged = mem_rsp_data;
        for (int j = 0; j < LANES; j++) begin
            if (off != 3'd0 && 3'(j) >= off)
                merged[j*WORD_WIDTH +: WORD_WIDTH] = hold[j*WORD_WIDTH +: WORD_WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            req_ready       <= 1'b1;
            mem_rd_valid    <= 1'b0;
            wptr            <= '0;
            off             <= '0;
            rem             <= '0;
            prime           <= 1'b0;
            hold            <= '0;
            out_valid       <= 1'b0;
            out_data        <= '0;
            out_align_start <= '0;
            out_last        <= 1'b0;
`ifdef UNALIGNED_FETCH_ERR_EN
            out_err         <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        wptr  <= req_addr[ADDR_WIDTH-1:3];
                        off   <= req_addr[2:0];
                        rem   <= req_len;
                        prime <= (req_addr[2:0] != 3'd0);
                        if (req_len != '0) begin
                            state        <= RD_ISSUE;
                            req_ready    <= 1'b0;
                            mem_rd_valid <= 1'b1;
                        end
                    end
                end
                RD_ISSUE: begin
                    if (mem_rd_ready) begin
                        wptr         <= wptr + 1'b1;
                        mem_rd_valid <= 1'b0;
                        state        <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (mem_rsp_valid) begin
`ifdef UNALIGNED_FETCH_ERR_EN
                        if (mem_rsp_err) begin
                            out_data        <= '0;
                            out_err         <= 1'b1;
                            out_last        <= 1'b1;
                            out_align_start <= off;
                            out_valid       <= 1'b1;
                            state           <= OUT;
                        end else
`endif
                        if (prime) begin
                            hold         <= mem_rsp_data;
                            prime        <= 1'b0;
                            mem_rd_valid <= 1'b1;
                            state        <= RD_ISSUE;
                        end else begin
                            out_data        <= merged;
                            out_align_start <= off;
                            out_last        <= (rem == LEN_WIDTH'(1));
                            hold            <= mem_rsp_data;
                            out_valid       <= 1'b1;
                            state           <= OUT;
                        end
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        rem       <= rem - 1'b1;
                        out_valid <= 1'b0;
`ifdef UNALIGNED_FETCH_ERR_EN
                        out_err   <= 1'b0;
`endif
                        if (out_last) begin
                            state     <= IDLE;
                            req_ready <= 1'b1;
                        end else begin
                            state        <= RD_ISSUE;
                            mem_rd_valid <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
